// File: rtl/ins_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Format codes, base opcodes and the request record carried through stage 1.
package ins_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_ISH = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6,
        FMT_RSV = 3'd7
    } fmt_t;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // All-zero is architecturally illegal, so it doubles as the error word.
    localparam logic [31:0] ILLEGAL_INS = 32'h0000_0000;

    typedef struct packed {
        fmt_t        fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } req_t;

endpackage

// File: rtl/ins_encoder_if.sv
// Request/response bundle between an instruction producer and the encoder.
// master = producer/consumer side, slave = encoder side.
interface ins_encoder_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           fmt;
    logic [6:0]           opcode;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [31:0]          imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          ins;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, ins, err, err_cnt
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, ins, err, err_cnt
    );

endinterface

// File: rtl/ins_imm_range_chk.sv
// Combinational encodability check: does the immediate fit the chosen format,
// is the format defined, and does the opcode carry the 32-bit marker bits.
module ins_imm_range_chk
    import ins_encoder_pkg::*;
(
    input  fmt_t        fmt,
    input  logic [1:0]  opcode_lsb,
    input  logic [31:0] imm,
    output logic        ok
);

    logic fits12;
    logic fits13;
    logic fits21;
    logic imm_ok;

    // A value fits an N-bit signed field when bits [31:N-1] are pure sign extension.
    assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);

    always_comb begin
        imm_ok = 1'b0;
        case (fmt)
            FMT_R:   imm_ok = 1'b1;
            FMT_I:   imm_ok = fits12;
            FMT_S:   imm_ok = fits12;
            FMT_ISH: imm_ok = (imm[31:5] == '0);
            FMT_B:   imm_ok = fits13 && !imm[0];
            FMT_U:   imm_ok = (imm[11:0] == '0);
            FMT_J:   imm_ok = fits21 && !imm[0];
            default: imm_ok = 1'b0;
        endcase
    end

    assign ok = imm_ok && (opcode_lsb == 2'b11);

endmodule

// File: rtl/ins_encoder.sv
// RV32I instruction encoder: two-stage valid/ready pipeline.
// Stage 1 captures the request and its encodability verdict, stage 2 holds the packed word.
module ins_encoder
    import ins_encoder_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    ins_encoder_if.slave bus
);

    req_t                 req_in;
    logic                 ok_in;

    req_t                 s1_req_reg;
    logic                 s1_ok_reg;
    logic                 s1_full_reg;

    logic                 s2_full_reg;
    logic [31:0]          ins_reg;
    logic                 err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    logic                 s2_ready;
    logic                 s1_adv;
    logic                 s1_load;
    logic                 hand_off;
    logic [31:0]          pack_word;

    always_comb begin
        req_in        = '0;
        req_in.fmt    = fmt_t'(bus.fmt);
        req_in.opcode = bus.opcode;
        req_in.rd     = bus.rd;
        req_in.rs1    = bus.rs1;
        req_in.rs2    = bus.rs2;
        req_in.funct3 = bus.funct3;
        req_in.funct7 = bus.funct7;
        req_in.imm    = bus.imm;
    end

    ins_imm_range_chk u_range_chk (
        .fmt        (req_in.fmt),
        .opcode_lsb (req_in.opcode[1:0]),
        .imm        (req_in.imm),
        .ok         (ok_in)
    );

    // Each stage refills in the same cycle its occupant leaves, so throughput is 1/cycle.
    assign hand_off     = s2_full_reg && bus.out_ready;
    assign s2_ready     = !s2_full_reg || bus.out_ready;
    assign s1_adv       = s1_full_reg && s2_ready;
    assign bus.in_ready = !s1_full_reg || s1_adv;
    assign s1_load      = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_full_reg <= 1'b0;
            s1_ok_reg   <= 1'b0;
            s1_req_reg  <= '0;
        end else begin
            if (s1_load) begin
                s1_full_reg <= 1'b1;
                s1_ok_reg   <= ok_in;
                s1_req_reg  <= req_in;
            end else if (s1_adv) begin
                s1_full_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        pack_word = ILLEGAL_INS;
        if (s1_ok_reg) begin
            case (s1_req_reg.fmt)
                FMT_R:   pack_word = {s1_req_reg.funct7, s1_req_reg.rs2, s1_req_reg.rs1,
                                      s1_req_reg.funct3, s1_req_reg.rd, s1_req_reg.opcode};
                FMT_I:   pack_word = {s1_req_reg.imm[11:0], s1_req_reg.rs1,
                                      s1_req_reg.funct3, s1_req_reg.rd, s1_req_reg.opcode};
                FMT_ISH: pack_word = {s1_req_reg.funct7, s1_req_reg.imm[4:0], s1_req_reg.rs1,
                                      s1_req_reg.funct3, s1_req_reg.rd, s1_req_reg.opcode};
                FMT_S:   pack_word = {s1_req_reg.imm[11:5], s1_req_reg.rs2, s1_req_reg.rs1,
                                      s1_req_reg.funct3, s1_req_reg.imm[4:0], s1_req_reg.opcode};
                FMT_B:   pack_word = {s1_req_reg.imm[12], s1_req_reg.imm[10:5], s1_req_reg.rs2,
                                      s1_req_reg.rs1, s1_req_reg.funct3, s1_req_reg.imm[4:1],
                                      s1_req_reg.imm[11], s1_req_reg.opcode};
                FMT_U:   pack_word = {s1_req_reg.imm[31:12], s1_req_reg.rd, s1_req_reg.opcode};
                FMT_J:   pack_word = {s1_req_reg.imm[20], s1_req_reg.imm[10:1], s1_req_reg.imm[11],
                                      s1_req_reg.imm[19:12], s1_req_reg.rd, s1_req_reg.opcode};
                default: pack_word = ILLEGAL_INS;
            endcase
        end
    end

    // ins/err only change when stage 1 advances, which cannot happen during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_full_reg <= 1'b0;
            ins_reg     <= ILLEGAL_INS;
            err_reg     <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_full_reg <= 1'b1;
                ins_reg     <= pack_word;
                err_reg     <= !s1_ok_reg;
            end else if (hand_off) begin
                s2_full_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (hand_off && err_reg && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign bus.out_valid = s2_full_reg;
    assign bus.ins       = ins_reg;
    assign bus.err       = err_reg;
    assign bus.err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_ins_encoder.sv
// Directed bench for ins_encoder: vector table, backpressure stream and mid-flight reset.
module tb_ins_encoder;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_ins;
        logic        exp_err;
    } vec_t;

    localparam int NV = 20;
    localparam int NB = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ins_encoder_if #(.ERR_CNT_W(16)) bus ();

    ins_encoder #(.ERR_CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vec_t vecs [NV];
    vec_t bp   [NB];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.fmt    = v.fmt;
        bus.opcode = v.op;
        bus.rd     = v.rd;
        bus.rs1    = v.rs1;
        bus.rs2    = v.rs2;
        bus.funct3 = v.f3;
        bus.funct7 = v.f7;
        bus.imm    = v.imm;
    endtask

    // One isolated transaction; called #1 after a clock edge with out_ready=1.
    task automatic run_one(input vec_t v, input int idx);
        int w;
        drive(v);
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("out_valid_after_accept", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check("out_valid_latency", 32'(bus.out_valid), 32'd1);
        check("ins", bus.ins, v.exp_ins);
        check("err", 32'(bus.err), 32'(v.exp_err));
        $display("vec %0d fmt=%0d op=0x%02h imm=0x%08h -> ins=0x%08h err=%0d",
                 idx, v.fmt, v.op, v.imm, bus.ins, bus.err);
        @(posedge clk); #1;
        if (v.exp_err) exp_cnt++;
        check("out_valid_after_handoff", 32'(bus.out_valid), 32'd0);
        check("err_cnt", 32'(bus.err_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hs_in;
        logic hs_out;
        int   acc;
        int   got;

        //                 fmt   op     rd  rs1 rs2 f3  f7     imm            exp_ins       err
        vecs[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h00500093, 1'b0};
        vecs[1]  = '{3'd3, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        32'h0020A423, 1'b0};
        vecs[2]  = '{3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
        vecs[3]  = '{3'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h001000EF, 1'b0};
        vecs[4]  = '{3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0};
        vecs[5]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF, 32'h002081B3, 1'b0};
        vecs[6]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0,        32'h402081B3, 1'b0};
        vecs[7]  = '{3'd2, 7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd31,       32'h41F15093, 1'b0};
        vecs[8]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0};
        vecs[9]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,     32'h7FF00093, 1'b0};
        vecs[10] = '{3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,     32'h7E000FE3, 1'b0};
        vecs[11] = '{3'd6, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000, 32'h8000006F, 1'b0};
        vecs[12] = '{3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,        32'h00000000, 1'b1};
        vecs[13] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h00000000, 1'b1};
        vecs[14] = '{3'd2, 7'h13, 5'd1, 5'd2, 5'd0, 3'd1, 7'h00, 32'd32,       32'h00000000, 1'b1};
        vecs[15] = '{3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 32'h00000000, 1'b1};
        vecs[16] = '{3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        32'h00000000, 1'b1};
        vecs[17] = '{3'd1, 7'h12, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        32'h00000000, 1'b1};
        vecs[18] = '{3'd4, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,     32'h00000000, 1'b1};
        vecs[19] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF7FF, 32'h00000000, 1'b1};

        bp[0] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1,        32'h00100093, 1'b0};
        bp[1] = '{3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2,        32'h00200113, 1'b0};
        bp[2] = '{3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF00193, 1'b0};
        bp[3] = '{3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,     32'h00000000, 1'b1};
        bp[4] = '{3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h00500293, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive('0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ins", bus.ins, 32'h0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid_after_release", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i < NV; i++) run_one(vecs[i], i);

        // Backpressure: 5 back-to-back requests, consumer stalled for the first 4 cycles
        acc = 0;
        got = 0;
        drive(bp[0]);
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && got < NB; cyc++) begin
            bus.out_ready = (cyc >= 4);
            #1;
            hs_in  = bus.in_valid && bus.in_ready;
            hs_out = bus.out_valid && bus.out_ready;
            if (cyc == 2 || cyc == 3) begin
                check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                check("bp_accepted_before_stall", 32'(acc), 32'd2);
                check("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
                check("bp_ins_held", bus.ins, bp[0].exp_ins);
            end
            if (hs_out) begin
                check("bp_ins", bus.ins, bp[got].exp_ins);
                check("bp_err", 32'(bus.err), 32'(bp[got].exp_err));
                check("bp_handoff_cycle", 32'(cyc), 32'(4 + got));
                $display("bp word %0d at cycle %0d -> ins=0x%08h err=%0d", got, cyc, bus.ins, bus.err);
                if (bp[got].exp_err) exp_cnt++;
                got++;
            end
            @(posedge clk); #1;
            if (hs_in) begin
                acc++;
                if (acc < NB) drive(bp[acc]);
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        check("bp_words_out", 32'(got), 32'(NB));
        check("bp_words_in", 32'(acc), 32'(NB));
        check("bp_err_cnt", 32'(bus.err_cnt), 32'(exp_cnt));

        // Reset with two words in flight
        bus.out_ready = 1'b0;
        drive(bp[0]);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        drive(bp[3]);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("inflight_out_valid", 32'(bus.out_valid), 32'd1);
        check("inflight_in_ready", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("midrst_ins", bus.ins, 32'h0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        $display("mid-flight reset applied: out_valid=%0d err_cnt=%0d", bus.out_valid, bus.err_cnt);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        exp_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("no_stale_word", 32'(bus.out_valid), 32'd0);
        end
        run_one(vecs[13], 100);
        run_one(vecs[4], 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
